// File: rtl/nn_pkg.sv
// +--------------------------------------------------------------------------+
// | nn_pkg : shared widths, state encoding and ReLU/saturate/round quantiser |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package nn_pkg;

    localparam int          DATA_W    = 8;
    localparam int          PROD_W    = 16;
    localparam int          ACC_W     = 23;
    localparam logic [7:0]  OUT_MAX   = 8'd127;
    localparam int          RND_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        QUANT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator is at x64 scale: drop 6 fractional bits with round-half-up,
    // clamp negatives to zero and anything above OUT_MAX to OUT_MAX.
    function automatic logic [DATA_W-1:0] quant_relu(input logic signed [ACC_W-1:0] acc);
        logic [DATA_W:0] r;
        r = {1'b0, acc[RND_SHIFT+DATA_W-1:RND_SHIFT]}
          + {{DATA_W{1'b0}}, acc[RND_SHIFT-1]};
        if (acc[ACC_W-1])
            quant_relu = '0;
        else if (|acc[ACC_W-2:RND_SHIFT+DATA_W-1])
            quant_relu = OUT_MAX;
        else if (r > {1'b0, OUT_MAX})
            quant_relu = OUT_MAX;
        else
            quant_relu = r[DATA_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/relu_quant.sv
// +--------------------------------------------------------------------------+
// | relu_quant : combinational wrapper around nn_pkg::quant_relu             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module relu_quant
    import nn_pkg::*;
(
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [DATA_W-1:0] o_q
);

    assign o_q = quant_relu(i_acc);

endmodule

`default_nettype wire

// File: rtl/node_3_seq.sv
// +--------------------------------------------------------------------------+
// | node_3_seq : time-multiplexed output neuron, one shared 8x8 MAC          |
// | Option macro NODE_3_PIPE_MUL_EN registers the product (one drain cycle). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module node_3_seq
    import nn_pkg::*;
#(
    parameter int                  N_IN  = 8,
    parameter logic [N_IN*8-1:0]   W_VEC = '0,
    parameter logic signed [15:0]  B0x   = 16'sd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN*8-1:0] in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int                 c_idx_w    = $clog2(N_IN);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_IN - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [N_IN*8-1:0]         r_vec;
    logic [c_idx_w-1:0]        r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         r_out;
    logic signed [DATA_W-1:0]  w_wt [N_IN];
    logic signed [DATA_W-1:0]  w_x;
    logic signed [DATA_W-1:0]  w_w;
    logic signed [PROD_W-1:0]  w_prod;
    logic [DATA_W-1:0]         w_q;
    logic                      w_last;
    logic                      w_mac_done;

    for (genvar i = 0; i < N_IN; i++) begin : g_wt
        assign w_wt[i] = W_VEC[8*i +: 8];
    end

    assign w_x    = r_vec[r_idx*8 +: 8];
    assign w_w    = w_wt[r_idx];
    assign w_prod = w_x * w_w;
    assign w_last = (r_idx == c_idx_last);

`ifdef NODE_3_PIPE_MUL_EN
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_pvld;
    logic                     r_drain;

    assign w_mac_done = r_drain;
`else
    assign w_mac_done = w_last;
`endif

    relu_quant u_relu_quant (
        .i_acc (r_acc),
        .o_q   (w_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = r_out;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid)
                    w_state_next = MAC;
            end
            MAC: begin
                if (w_mac_done)
                    w_state_next = QUANT;
            end
            QUANT: begin
                w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
`ifdef NODE_3_PIPE_MUL_EN
            r_prod  <= '0;
            r_pvld  <= 1'b0;
            r_drain <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vec <= in_vec;
                        r_acc <= ACC_W'(B0x);
                        r_idx <= '0;
                    end
                end
                MAC: begin
`ifdef NODE_3_PIPE_MUL_EN
                    // Product stage runs one cycle ahead of the accumulate stage.
                    if (!r_drain) begin
                        r_prod <= w_prod;
                        r_pvld <= 1'b1;
                        if (w_last) begin
                            r_drain <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    if (r_pvld)
                        r_acc <= r_acc + ACC_W'(r_prod);
                    if (r_drain) begin
                        r_drain <= 1'b0;
                        r_pvld  <= 1'b0;
                    end
`else
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
`endif
                end
                QUANT: begin
                    r_out <= w_q;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
